// File: rtl/show_cmd_sequencer.sv
// Command sequencer for the rect/ASCII overlay stage: buffers draw commands in a
// small FIFO and holds each one on the overlay parameter inputs for its exact dwell.
module show_cmd_sequencer #(
   parameter int A_W        = 8,
   parameter int L_W        = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int PIPE_PAD   = 4
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [A_W-1:0] cmd_ascii,
   input  logic [2:0]     cmd_color,
   input  logic [L_W-1:0] cmd_x1,
   input  logic [L_W-1:0] cmd_y1,
   input  logic [L_W-1:0] cmd_x2,
   input  logic [L_W-1:0] cmd_y2,
   output logic [A_W-1:0] o_ascii,
   output logic [2:0]     o_color,
   output logic [L_W-1:0] o_x,
   output logic [L_W-1:0] o_y,
   output logic [L_W-1:0] o_x1,
   output logic [L_W-1:0] o_y1,
   output logic [L_W-1:0] o_x2,
   output logic [L_W-1:0] o_y2,
   output logic [L_W-1:0] o_ys,
   output logic [L_W-1:0] o_ye,
   output logic           o_busy,
   output logic           o_err
);

   localparam int CMD_W = A_W + 3 + 4*L_W;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DW_W  = 17;

   localparam logic [A_W-1:0] OP_CLEAR   = A_W'(0);
   localparam logic [A_W-1:0] OP_RECT    = A_W'(1);
   localparam logic [A_W-1:0] OP_NOOP    = A_W'(32);
   localparam logic [A_W-1:0] PARK_ASCII = A_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_stateNext;

   logic [CMD_W-1:0] r_fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   logic [A_W-1:0] w_headAscii;
   logic [2:0]     w_headColor;
   logic [L_W-1:0] w_headX1;
   logic [L_W-1:0] w_headY1;
   logic [L_W-1:0] w_headX2;
   logic [L_W-1:0] w_headY2;

   logic [A_W-1:0] r_cmdAscii;
   logic [2:0]     r_cmdColor;
   logic [L_W-1:0] r_cmdX1;
   logic [L_W-1:0] r_cmdY1;
   logic [L_W-1:0] r_cmdX2;
   logic [L_W-1:0] r_cmdY2;

   logic           w_isClear;
   logic           w_isRect;
   logic           w_isNoop;
   logic           w_isGlyph;
   logic [L_W-1:0] w_dx;
   logic [L_W-1:0] w_dy;
   logic [DW_W-1:0] w_dwell;
   logic           w_legal;
   logic           w_load;
   logic           w_park;
   logic           w_errSet;

   logic [DW_W-1:0] r_dwellCnt;
   logic [A_W-1:0]  r_outAscii;
   logic [2:0]      r_outColor;
   logic [L_W-1:0]  r_outX;
   logic [L_W-1:0]  r_outY;
   logic [L_W-1:0]  r_outX1;
   logic [L_W-1:0]  r_outY1;
   logic [L_W-1:0]  r_outX2;
   logic [L_W-1:0]  r_outY2;
   logic [L_W-1:0]  r_outYs;
   logic [L_W-1:0]  r_outYe;
   logic            r_err;

   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign cmd_ready = !w_full;
   assign w_push    = cmd_valid && !w_full;

   // Storage has no reset; only the pointers and count define what is valid.
   always_ff @(posedge sys_clk) begin
      if (w_push) begin
         r_fifoMem[r_wrPtr] <= {cmd_ascii, cmd_color, cmd_x1, cmd_y1, cmd_x2, cmd_y2};
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign {w_headAscii, w_headColor, w_headX1, w_headY1, w_headX2, w_headY2} = r_fifoMem[r_rdPtr];

   assign w_isClear = (r_cmdAscii == OP_CLEAR);
   assign w_isRect  = (r_cmdAscii == OP_RECT);
   assign w_isNoop  = (r_cmdAscii == OP_NOOP);
   assign w_isGlyph = !w_isClear && !w_isRect && !w_isNoop;
   assign w_dx      = r_cmdX2 - r_cmdX1;
   assign w_dy      = r_cmdY2 - r_cmdY1;

   // Differences are only meaningful once the ordering check has passed.
   always_comb begin
      w_legal = 1'b1;
      w_dwell = DW_W'(1);
      if (w_isClear) begin
         w_legal = (r_cmdY2 >= r_cmdY1);
         w_dwell = ((DW_W'(w_dy) + DW_W'(1)) << 8) + DW_W'(PIPE_PAD);
      end else if (w_isRect) begin
         w_legal = (r_cmdX2 >= r_cmdX1) && (r_cmdY2 >= r_cmdY1);
         w_dwell = ((DW_W'(w_dx) + DW_W'(w_dy)) << 1) + DW_W'(PIPE_PAD);
      end else if (w_isGlyph) begin
         w_dwell = DW_W'(128 + PIPE_PAD);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_park      = 1'b0;
      w_errSet    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_stateNext = CALC;
            end
         end
         CALC: begin
            if (w_legal) begin
               w_load      = 1'b1;
               w_stateNext = ISSUE;
            end else begin
               w_errSet    = 1'b1;
               w_stateNext = IDLE;
            end
         end
         ISSUE: begin
            if (r_dwellCnt == '0) begin
               w_park = 1'b1;
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_stateNext = CALC;
               end else begin
                  w_stateNext = IDLE;
               end
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // All overlay fields switch together on the CALC->ISSUE and ISSUE->park edges.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cmdAscii <= '0;
         r_cmdColor <= '0;
         r_cmdX1    <= '0;
         r_cmdY1    <= '0;
         r_cmdX2    <= '0;
         r_cmdY2    <= '0;
         r_dwellCnt <= '0;
         r_outAscii <= PARK_ASCII;
         r_outColor <= '0;
         r_outX     <= '0;
         r_outY     <= '0;
         r_outX1    <= '0;
         r_outY1    <= '0;
         r_outX2    <= '0;
         r_outY2    <= '0;
         r_outYs    <= '0;
         r_outYe    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_errSet;
         if (w_pop) begin
            r_cmdAscii <= w_headAscii;
            r_cmdColor <= w_headColor;
            r_cmdX1    <= w_headX1;
            r_cmdY1    <= w_headY1;
            r_cmdX2    <= w_headX2;
            r_cmdY2    <= w_headY2;
         end
         if (w_load) begin
            r_dwellCnt <= w_dwell - DW_W'(1);
            r_outAscii <= r_cmdAscii;
            r_outColor <= r_cmdColor;
            r_outX     <= w_isGlyph ? r_cmdX1 : '0;
            r_outY     <= w_isGlyph ? r_cmdY1 : '0;
            r_outX1    <= w_isRect  ? r_cmdX1 : '0;
            r_outY1    <= w_isRect  ? r_cmdY1 : '0;
            r_outX2    <= w_isRect  ? r_cmdX2 : '0;
            r_outY2    <= w_isRect  ? r_cmdY2 : '0;
            r_outYs    <= w_isClear ? r_cmdY1 : '0;
            r_outYe    <= w_isClear ? r_cmdY2 : '0;
         end else begin
            if (r_dwellCnt != '0) begin
               r_dwellCnt <= r_dwellCnt - DW_W'(1);
            end
            if (w_park) begin
               r_outAscii <= PARK_ASCII;
               r_outX     <= '0;
               r_outY     <= '0;
               r_outX1    <= '0;
               r_outY1    <= '0;
               r_outX2    <= '0;
               r_outY2    <= '0;
               r_outYs    <= '0;
               r_outYe    <= '0;
            end
         end
      end
   end

   assign o_ascii = r_outAscii;
   assign o_color = r_outColor;
   assign o_x     = r_outX;
   assign o_y     = r_outY;
   assign o_x1    = r_outX1;
   assign o_y1    = r_outY1;
   assign o_x2    = r_outX2;
   assign o_y2    = r_outY2;
   assign o_ys    = r_outYs;
   assign o_ye    = r_outYe;
   assign o_err   = r_err;
   assign o_busy  = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_show_cmd_sequencer.sv
// Randomised scoreboard bench for show_cmd_sequencer: every accepted command queues
// its expected overlay bundle and dwell; a negedge monitor pops and compares.
module tb_show_cmd_sequencer;

   localparam int A_W      = 8;
   localparam int L_W      = 8;
   localparam int PIPE_PAD = 4;

   logic           sys_clk = 1'b0;
   logic           sys_rst_n = 1'b1;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [A_W-1:0] cmd_ascii;
   logic [2:0]     cmd_color;
   logic [L_W-1:0] cmd_x1, cmd_y1, cmd_x2, cmd_y2;
   logic [A_W-1:0] o_ascii;
   logic [2:0]     o_color;
   logic [L_W-1:0] o_x, o_y, o_x1, o_y1, o_x2, o_y2, o_ys, o_ye;
   logic           o_busy;
   logic           o_err;

   show_cmd_sequencer #(.A_W(A_W), .L_W(L_W), .FIFO_DEPTH(4), .PIPE_PAD(PIPE_PAD)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ascii(cmd_ascii), .cmd_color(cmd_color),
      .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_x2(cmd_x2), .cmd_y2(cmd_y2),
      .o_ascii(o_ascii), .o_color(o_color), .o_x(o_x), .o_y(o_y),
      .o_x1(o_x1), .o_y1(o_y1), .o_x2(o_x2), .o_y2(o_y2),
      .o_ys(o_ys), .o_ye(o_ye), .o_busy(o_busy), .o_err(o_err)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [7:0] ascii;
      logic [2:0] color;
      logic [7:0] x, y, x1, y1, x2, y2, ys, ye;
   } bundle_t;

   typedef struct {
      bit      isErr;
      bundle_t val;
      int      dwell;
   } expect_t;

   expect_t expQ[$];
   int      gapQ[$];
   int      checks = 0;
   int      failures = 0;
   int      cycle = 0;
   int      negCount = 0;
   int      lastClose = 0;
   int      lastAcc = 0;
   bit      monEn = 0;
   bit      segOpen = 0;
   int      segLen = 0;
   bundle_t segVal;
   bundle_t curVal;
   expect_t monExp;

   always @(posedge sys_clk) cycle++;

   // Reference model: overlay fields and dwell straight from the command's meaning.
   function automatic expect_t refModel(input int asc, input int col, input int x1,
                                        input int y1, input int x2, input int y2);
      expect_t e;
      e.isErr     = 0;
      e.val       = '0;
      e.val.ascii = asc[7:0];
      e.val.color = col[2:0];
      e.dwell     = 0;
      if (asc == 0) begin
         if (y2 < y1) e.isErr = 1;
         else begin
            e.val.ys = y1[7:0];
            e.val.ye = y2[7:0];
            e.dwell  = 256 * (y2 - y1 + 1) + PIPE_PAD;
         end
      end else if (asc == 1) begin
         if (x2 < x1 || y2 < y1) e.isErr = 1;
         else begin
            e.val.x1 = x1[7:0];
            e.val.y1 = y1[7:0];
            e.val.x2 = x2[7:0];
            e.val.y2 = y2[7:0];
            e.dwell  = 2 * ((x2 - x1) + (y2 - y1)) + PIPE_PAD;
         end
      end else if (asc == 32) begin
         e.dwell = 1;
      end else begin
         e.val.x = x1[7:0];
         e.val.y = y1[7:0];
         e.dwell = 128 + PIPE_PAD;
      end
      return e;
   endfunction

   function automatic bundle_t sampleBundle();
      bundle_t b;
      b.ascii = o_ascii; b.color = o_color;
      b.x = o_x; b.y = o_y; b.x1 = o_x1; b.y1 = o_y1;
      b.x2 = o_x2; b.y2 = o_y2; b.ys = o_ys; b.ye = o_ye;
      return b;
   endfunction

   function automatic bit isPark(input bundle_t b);
      return (b.ascii == 8'd1) && (b.x == 0) && (b.y == 0) && (b.x1 == 0) && (b.y1 == 0) &&
             (b.x2 == 0) && (b.y2 == 0) && (b.ys == 0) && (b.ye == 0);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic checkBundle(input string name, input bundle_t act, input bundle_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic checkResetState(input string tag);
      bundle_t rb;
      rb       = '0;
      rb.ascii = 8'd1;
      checkBundle({tag, "_outputs"}, sampleBundle(), rb);
      checkOutput({tag, "_ready"}, {31'b0, cmd_ready}, 32'd1);
      checkOutput({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
      checkOutput({tag, "_err"}, {31'b0, o_err}, 32'd0);
   endtask

   // Monitor: a run of identical non-park bundles is one issued command.
   always @(negedge sys_clk) begin
      negCount++;
      if (!monEn) begin
         segOpen = 0;
      end else begin
         curVal = sampleBundle();
         if (segOpen && curVal != segVal) begin
            if (expQ.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL issue_unexpected actual=%h expected=none", segVal);
            end else begin
               monExp = expQ.pop_front();
               if (monExp.isErr) begin
                  checks++; failures++;
                  $display("[TB] FAIL issue_vs_err actual=issued %h expected=o_err", segVal);
               end else begin
                  checkBundle("issue_fields", segVal, monExp.val);
                  checkOutput("issue_dwell", segLen, monExp.dwell);
               end
            end
            checkOutput("gap_parked", {31'b0, isPark(curVal)}, 32'd1);
            segOpen   = 0;
            lastClose = negCount;
         end else if (segOpen) begin
            segLen++;
         end
         if (!segOpen && !isPark(curVal)) begin
            segOpen = 1;
            segVal  = curVal;
            segLen  = 1;
            gapQ.push_back(negCount - lastClose);
         end
         if (o_err) begin
            if (expQ.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL err_unexpected actual=1 expected=none");
            end else begin
               monExp = expQ.pop_front();
               checkOutput("err_expected", {31'b0, o_err}, {31'b0, monExp.isErr});
            end
         end
      end
   end

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // Called #1 after a posedge; leaves cmd_valid high so back-to-back calls stream.
   task automatic applyStimulus(input int asc, input int col, input int x1,
                                input int y1, input int x2, input int y2);
      bit   done;
      int   waitCnt;
      logic rdy;
      done = 0;
      waitCnt = 0;
      cmd_valid = 1'b1;
      cmd_ascii = asc[7:0];
      cmd_color = col[2:0];
      cmd_x1 = x1[7:0]; cmd_y1 = y1[7:0];
      cmd_x2 = x2[7:0]; cmd_y2 = y2[7:0];
      while (!done) begin
         rdy = cmd_ready;
         @(posedge sys_clk);
         #1;
         if (rdy) begin
            done = 1;
            lastAcc = cycle;
            expQ.push_back(refModel(asc, col, x1, y1, x2, y2));
         end else if (++waitCnt > 5000) begin
            checks++; failures++;
            $display("[TB] FAIL accept_timeout actual=not_accepted expected=accepted");
            done = 1;
         end
      end
   endtask

   task automatic drainAll();
      int guard;
      guard = 0;
      cmd_valid = 1'b0;
      while ((expQ.size() != 0 || o_busy || segOpen) && guard < 30000) begin
         stepCycles(1);
         guard++;
      end
      stepCycles(2);
      checkOutput("drain_queue_empty", expQ.size(), 0);
      checkOutput("drain_busy_low", {31'b0, o_busy}, 32'd0);
   endtask

   int accCycle[6];
   int kind, a, c, x1, y1, x2, y2, n, guard, stale;

   initial begin
      cmd_valid = 0; cmd_ascii = 0; cmd_color = 0;
      cmd_x1 = 0; cmd_y1 = 0; cmd_x2 = 0; cmd_y2 = 0;
      #2 sys_rst_n = 1'b0;
      stepCycles(3);
      checkResetState("in_reset");
      @(negedge sys_clk) sys_rst_n = 1'b1;
      stepCycles(10);
      checkResetState("idle10");
      monEn = 1;

      // Glyph latency: accepted at cycle 0, parked at 1, visible at 2.
      applyStimulus(65, 3, 10, 20, 0, 0);
      cmd_valid = 1'b0;
      stepCycles(1);
      checkOutput("glyph_c1_parked", {24'b0, o_ascii}, 32'd1);
      stepCycles(1);
      checkOutput("glyph_c2_ascii", {24'b0, o_ascii}, 32'd65);
      checkOutput("glyph_c2_x", {24'b0, o_x}, 32'd10);
      checkOutput("glyph_c2_y", {24'b0, o_y}, 32'd20);
      drainAll();

      applyStimulus(1, 5, 5, 5, 9, 7);
      applyStimulus(1, 2, 9, 5, 5, 7);
      applyStimulus(1, 6, 30, 40, 30, 40);
      applyStimulus(0, 1, 0, 0, 0, 1);
      applyStimulus(0, 4, 0, 3, 0, 2);
      applyStimulus(32, 7, 0, 0, 0, 0);
      drainAll();

      // Burst of six glyphs with cmd_valid held high.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(66 + i, i, i * 3, i * 5, 0, 0);
         accCycle[i] = lastAcc;
      end
      drainAll();
      checkOutput("burst_first5_back2back", accCycle[4] - accCycle[0], 4);
      checkOutput("burst_sixth_stall", accCycle[5] - accCycle[4], 131);
      n = gapQ.size();
      if (n >= 5) begin
         for (int i = n - 5; i < n; i++) checkOutput("burst_gap_one", gapQ[i], 1);
      end else begin
         checks++; failures++;
         $display("[TB] FAIL burst_gap_count actual=%0d expected>=5", n);
      end

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(5, 0);
         c  = $urandom_range(7, 0);
         x1 = $urandom_range(255, 0); y1 = $urandom_range(255, 0);
         x2 = $urandom_range(255, 0); y2 = $urandom_range(255, 0);
         case (kind)
            0: begin a = 0; y1 = $urandom_range(250, 0); y2 = y1 + $urandom_range(2, 0); end
            1: begin a = 0; y1 = $urandom_range(255, 1); y2 = y1 - 1; end
            2: begin
               a = 1;
               x1 = $urandom_range(200, 0); x2 = x1 + $urandom_range(30, 0);
               y1 = $urandom_range(200, 0); y2 = y1 + $urandom_range(30, 0);
               if (x1 == 0 && y1 == 0 && x2 == 0 && y2 == 0) x2 = 1;
            end
            3: begin a = 1; x1 = $urandom_range(255, 1); x2 = $urandom_range(x1 - 1, 0); end
            4: begin a = $urandom_range(127, 2); if (a == 32) a = 33; end
            default: a = 32;
         endcase
         applyStimulus(a, c, x1, y1, x2, y2);
         cmd_valid = 1'b0;
         stepCycles($urandom_range(3, 0));
      end
      drainAll();

      // Reset in the middle of a glyph with a second glyph still queued.
      monEn = 0;
      stepCycles(1);
      applyStimulus(70, 5, 1, 2, 0, 0);
      applyStimulus(71, 6, 3, 4, 0, 0);
      cmd_valid = 1'b0;
      expQ.delete();
      guard = 0;
      while (o_ascii != 8'd70 && guard < 100) begin
         stepCycles(1);
         guard++;
      end
      checkOutput("rst_glyph_started", {24'b0, o_ascii}, 32'd70);
      stepCycles(10);
      #2 sys_rst_n = 1'b0;
      #1;
      checkResetState("rst_mid_issue");
      @(negedge sys_clk) sys_rst_n = 1'b1;
      stale = 0;
      repeat (300) begin
         @(negedge sys_clk);
         if (o_ascii != 8'd1 || o_busy) stale++;
      end
      checkOutput("rst_no_stale_issue", stale, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/show_cmd_sequencer.md
Name: show_cmd_sequencer

Overview:
- Upstream command sequencer for the single-layer rect/ASCII overlay stage.
- Accepts draw commands (clear band, rectangle outline, glyph, no-op) over a valid/ready handshake and buffers them in a small FIFO.
- Presents one command at a time on the overlay stage's parameter inputs, holding all fields stable in the same cycle for exactly the dwell that command needs.
- Between commands, parks the outputs on the "draw nothing" pattern.

Parameters:
- A_W, `ASCII_WIDTH, width of the ascii/opcode field.
- L_W, `LETTER_PIXEL_WIDTH, width of every coordinate (8: overlay grid is 256x256).
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2, at least 2.
- PIPE_PAD, 4, extra dwell cycles covering the downstream 2-stage pipeline plus margin.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  async active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full; a transfer occurs when cmd_valid && cmd_ready.
- cmd_ascii  in  A_W  opcode: 0 = clear, 1 = rect, 32 = no-op, else glyph code.
- cmd_color  in  3  colour.
- cmd_x1  in  L_W  rect x1 / glyph x.
- cmd_y1  in  L_W  rect y1 / glyph y / clear ys.
- cmd_x2  in  L_W  rect x2.
- cmd_y2  in  L_W  rect y2 / clear ye.
- o_ascii  out  A_W  to overlay i_ascii.
- o_color  out  3  to overlay i_color.
- o_x, o_y  out  L_W each  glyph origin.
- o_x1, o_y1, o_x2, o_y2  out  L_W each  rect corners.
- o_ys, o_ye  out  L_W each  clear band.
- o_busy  out  1  FSM not IDLE, or FIFO not empty.
- o_err  out  1  one-cycle pulse when an illegal command is discarded.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous and active-low on sys_rst_n.
- Reset values:
  - o_ascii = 1; all coordinate outputs = 0; o_color = 0.
  - o_busy = 0; o_err = 0; FIFO empty; cmd_ready = 1; FSM = IDLE.
- Park pattern: o_ascii = 1, all coordinates = 0, colour held. Driven in IDLE and CALC.
- FIFO:
  - Synchronous, registered, first-word-fall-through internally.
  - cmd_ready = !full.
  - Push and pop in the same cycle when full is legal only because ready is already low. When not full, a simultaneous push and pop keeps the count unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the command register and go to CALC.
  - CALC: compute dwell D (17-bit) from the command register.
    - Clear: D = 256*(ye-ys+1) + PIPE_PAD. Illegal if ye < ys.
    - Rect: D = 2*((x2-x1)+(y2-y1)) + PIPE_PAD. Illegal if x2 < x1 or y2 < y1. A degenerate rect (x1==x2 and y1==y2) is legal, D = PIPE_PAD.
    - Glyph: D = 128 + PIPE_PAD.
    - No-op (32): D = 1.
    - Illegal: pulse o_err, go to IDLE, outputs stay parked.
    - Legal: load the dwell counter with D-1 and go to ISSUE.
  - ISSUE: all o_* fields driven from the command register, updated together on the CALC->ISSUE edge.
    - Clear maps cmd_y1 to o_ys and cmd_y2 to o_ye.
    - Glyph maps cmd_x1/cmd_y1 to o_x/o_y.
    - Unused fields are 0.
    - The counter decrements each cycle; ISSUE lasts exactly D cycles.
    - At count 0: if the FIFO is non-empty, pop and go to CALC; otherwise go to IDLE. Outputs park on that edge.
- Latency: a command accepted at edge N into an empty FIFO while the FSM is idle is popped at N+1 and appears on o_* at N+2.
- Gap: at least one parked cycle (CALC) separates consecutive commands.
- Reset mid-ISSUE: outputs park immediately (async) and FIFO contents are lost.
- Arithmetic: all differences are taken on L_W-bit unsigned values after the legality check, then zero-extended to 17 bits.

Test Plan:
- Reset, then idle 10 cycles -> o_ascii=1, coordinates 0, cmd_ready=1, o_busy=0.
- Single glyph ascii=65, x1=10, y1=20, colour=3 accepted at cycle 0 -> o_ascii=65, o_x=10, o_y=20 from cycle 2 through 133 (132 cycles), park at cycle 134, o_busy falls after.
- Rect (5,5)-(9,7) -> ISSUE for 2*(4+2)+4=16 cycles. Rect (9,5)-(5,7) -> o_err pulse, no ISSUE, outputs stay parked.
- Clear ys=0, ye=1 -> o_ascii=0, o_ys=0, o_ye=1 for 516 cycles. Clear ys=3, ye=2 -> o_err.
- Burst of 6 commands with cmd_valid held high -> cmd_ready drops after 4 accepted (5 once the first pop frees an entry); all 6 are issued in order, each separated by exactly one parked cycle.
- Assert sys_rst_n low mid-ISSUE of a glyph -> outputs immediately return to reset values; after release no stale command is issued.
